// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline hazard sequencer.
//   hz_state_e : sequencer FSM states (RUN, FLUSH, MEM_WAIT)
//   fwd_sel_e  : execute operand source select encoding
//   reg_match  : true when a valid, non-x0 destination matches a source index
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        FLUSH    = 2'b01,
        MEM_WAIT = 2'b10
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    function automatic logic reg_match(input logic [4:0] rd_addr,
                                       input logic       rd_valid,
                                       input logic [4:0] rs_addr);
        return rd_valid && (rd_addr != 5'd0) && (rd_addr == rs_addr);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one execute source operand.
// Ports:
//   rs_addr_i   in  5  source register index of the operand
//   rdM_addr_i  in  5  memory-stage destination index
//   rdM_valid_i in  1  memory-stage result valid
//   rdW_addr_i  in  5  writeback-stage destination index
//   rdW_valid_i in  1  writeback-stage result valid
//   sel_o       out 2  FWD_RF / FWD_MEM / FWD_WB
module hazard_fwd_unit
    import riscv_pkg::*;
(
    input  logic [4:0] rs_addr_i,
    input  logic [4:0] rdM_addr_i,
    input  logic       rdM_valid_i,
    input  logic [4:0] rdW_addr_i,
    input  logic       rdW_valid_i,
    output fwd_sel_e   sel_o
);

    // Memory stage holds the younger result, so it wins over writeback.
    always_comb begin
        sel_o = FWD_RF;
        if (reg_match(rdM_addr_i, rdM_valid_i, rs_addr_i)) begin
            sel_o = FWD_MEM;
        end else if (reg_match(rdW_addr_i, rdW_valid_i, rs_addr_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32I core: stall/flush controls for
// fetch, decode and execute plus operand forwarding selects for execute.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   rs1D/rs2D_addr_i, rs1D/rs2D_used_i        decode source operands
//   rdE_addr_i, rdE_wrt_ena_i, loadE_i         execute destination / load flag
//   rdM_addr_i, rdM_valid_i, rdW_addr_i, rdW_valid_i  forwarding producers
//   next_pc_ena_i                              redirect pulse from execute
//   dmem_req_i, dmem_ack_i                     data memory handshake
//   stallF/D/E_o, flushD/E_o                   stage controls (combinational)
//   fwd_rs1_sel_o, fwd_rs2_sel_o               00 regfile, 01 M, 10 W
//   stall_cnt_o                                saturating stallF cycle count
// Operand selects are decoded from the rs1D/rs2D index inputs; the core
// presents on these the indices of the operands being selected.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       rs1D_addr_i,
    input  logic [4:0]       rs2D_addr_i,
    input  logic             rs1D_used_i,
    input  logic             rs2D_used_i,
    input  logic [4:0]       rdE_addr_i,
    input  logic             rdE_wrt_ena_i,
    input  logic             loadE_i,
    input  logic [4:0]       rdM_addr_i,
    input  logic             rdM_valid_i,
    input  logic [4:0]       rdW_addr_i,
    input  logic             rdW_valid_i,
    input  logic             next_pc_ena_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             stallF_o,
    output logic             stallD_o,
    output logic             stallE_o,
    output logic             flushD_o,
    output logic             flushE_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int FC_W = $clog2(FLUSH_CYCLES) + 1;
    // Entered from RUN after the redirect cycle itself already flushed.
    localparam logic [FC_W-1:0] CNT_RESTART =
        (FLUSH_CYCLES > 1) ? FC_W'(FLUSH_CYCLES - 2) : {FC_W{1'b0}};
    // Entered after a memory ack: all FLUSH_CYCLES flush cycles still ahead.
    localparam logic [FC_W-1:0] CNT_FULL = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    hz_state_e        state_q, state_d;
    logic [FC_W-1:0]  cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic     load_use_s;
    logic     stall_f_s, stall_d_s, stall_e_s, flush_d_s, flush_e_s;
    fwd_sel_e fwd_rs1_s, fwd_rs2_s;

    // Load result is not available until after M, so a dependent decode op must wait one cycle.
    always_comb begin
        load_use_s = loadE_i && rdE_wrt_ena_i && (rdE_addr_i != 5'd0) &&
                     ((rs1D_used_i && (rs1D_addr_i == rdE_addr_i)) ||
                      (rs2D_used_i && (rs2D_addr_i == rdE_addr_i)));
    end

    // Next-state and stall/flush decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        stall_f_s = 1'b0;
        stall_d_s = 1'b0;
        stall_e_s = 1'b0;
        flush_d_s = 1'b0;
        flush_e_s = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_req_i && !dmem_ack_i) begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    stall_e_s = 1'b1;
                    state_d   = MEM_WAIT;
                    pend_d    = next_pc_ena_i;
                end else if (next_pc_ena_i) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_RESTART;
                    end else begin
                        state_d = RUN;
                    end
                end else if (load_use_s) begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    flush_e_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                flush_d_s = 1'b1;
                flush_e_s = 1'b1;
                if (next_pc_ena_i) begin
                    cnt_d = CNT_RESTART;
                end else if (cnt_q == {FC_W{1'b0}}) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - FC_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ack_i) begin
                    // Stalls release on the ack cycle; a held redirect flushes from the next cycle.
                    pend_d = 1'b0;
                    if (pend_q || next_pc_ena_i) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_FULL;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    stall_f_s = 1'b1;
                    stall_d_s = 1'b1;
                    stall_e_s = 1'b1;
                    pend_d    = pend_q || next_pc_ena_i;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = {FC_W{1'b0}};
                pend_d  = 1'b0;
            end
        endcase
        // Reset squashes decode/execute and releases all stalls.
        if (rst_i) begin
            stall_f_s = 1'b0;
            stall_d_s = 1'b0;
            stall_e_s = 1'b0;
            flush_d_s = 1'b1;
            flush_e_s = 1'b1;
        end else begin
            pend_d = pend_d;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, flush counter, pending redirect and performance counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            cnt_q       <= {FC_W{1'b0}};
            pend_q      <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    hazard_fwd_unit u_fwd_rs1 (
        .rs_addr_i   (rs1D_addr_i),
        .rdM_addr_i  (rdM_addr_i),
        .rdM_valid_i (rdM_valid_i),
        .rdW_addr_i  (rdW_addr_i),
        .rdW_valid_i (rdW_valid_i),
        .sel_o       (fwd_rs1_s)
    );

    hazard_fwd_unit u_fwd_rs2 (
        .rs_addr_i   (rs2D_addr_i),
        .rdM_addr_i  (rdM_addr_i),
        .rdM_valid_i (rdM_valid_i),
        .rdW_addr_i  (rdW_addr_i),
        .rdW_valid_i (rdW_valid_i),
        .sel_o       (fwd_rs2_s)
    );

    assign stallF_o      = stall_f_s;
    assign stallD_o      = stall_d_s;
    assign stallE_o      = stall_e_s;
    assign flushD_o      = flush_d_s;
    assign flushE_o      = flush_e_s;
    assign fwd_rs1_sel_o = rst_i ? 2'b00 : fwd_rs1_s;
    assign fwd_rs2_sel_o = rst_i ? 2'b00 : fwd_rs2_s;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; a second instance (CNT_W=2,
// FLUSH_CYCLES=1) shares the stimulus to reach counter saturation and the
// single-cycle flush case.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1D, rs2D, rdE, rdM, rdW;
    logic       rs1_used, rs2_used, rdE_wrt, loadE, rdM_valid, rdW_valid;
    logic       next_pc, req, ack;

    logic        stallF, stallD, stallE, flushD, flushE;
    logic [1:0]  fwd1, fwd2;
    logic [31:0] scnt;
    logic        s_stallF, s_stallD, s_stallE, s_flushD, s_flushE;
    logic [1:0]  s_fwd1, s_fwd2;
    logic [1:0]  s_scnt;

    wire [4:0] ctl   = {stallF, stallD, stallE, flushD, flushE};
    wire [4:0] s_ctl = {s_stallF, s_stallD, s_stallE, s_flushD, s_flushE};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs1D_addr_i(rs1D), .rs2D_addr_i(rs2D),
        .rs1D_used_i(rs1_used), .rs2D_used_i(rs2_used),
        .rdE_addr_i(rdE), .rdE_wrt_ena_i(rdE_wrt), .loadE_i(loadE),
        .rdM_addr_i(rdM), .rdM_valid_i(rdM_valid),
        .rdW_addr_i(rdW), .rdW_valid_i(rdW_valid),
        .next_pc_ena_i(next_pc), .dmem_req_i(req), .dmem_ack_i(ack),
        .stallF_o(stallF), .stallD_o(stallD), .stallE_o(stallE),
        .flushD_o(flushD), .flushE_o(flushE),
        .fwd_rs1_sel_o(fwd1), .fwd_rs2_sel_o(fwd2), .stall_cnt_o(scnt)
    );

    hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst),
        .rs1D_addr_i(rs1D), .rs2D_addr_i(rs2D),
        .rs1D_used_i(rs1_used), .rs2D_used_i(rs2_used),
        .rdE_addr_i(rdE), .rdE_wrt_ena_i(rdE_wrt), .loadE_i(loadE),
        .rdM_addr_i(rdM), .rdM_valid_i(rdM_valid),
        .rdW_addr_i(rdW), .rdW_valid_i(rdW_valid),
        .next_pc_ena_i(next_pc), .dmem_req_i(req), .dmem_ack_i(ack),
        .stallF_o(s_stallF), .stallD_o(s_stallD), .stallE_o(s_stallE),
        .flushD_o(s_flushD), .flushE_o(s_flushE),
        .fwd_rs1_sel_o(s_fwd1), .fwd_rs2_sel_o(s_fwd2), .stall_cnt_o(s_scnt)
    );

    task automatic set_idle();
        rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
        rs1_used = 1'b0; rs2_used = 1'b0; rdE_wrt = 1'b0; loadE = 1'b0;
        rdM_valid = 1'b0; rdW_valid = 1'b0;
        next_pc = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        set_idle();
    endtask

    task automatic apply_reset();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b1; rdM = 5'd7; rdM_valid = 1'b1; rs1D = 5'd7; req = 1'b1;
        #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL reset_ctl: got %b exp %b", ctl, 5'b00011); errors++; end
        checks++; if (fwd1 !== 2'b00) begin $display("FAIL reset_fwd: got %b exp %b", fwd1, 2'b00); errors++; end
        next_cycle();
        rst = 1'b0;
        #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL reset_release_ctl: got %b exp %b", ctl, 5'b00000); errors++; end
        checks++; if (scnt !== 32'd0) begin $display("FAIL reset_cnt: got %0d exp 0", scnt); errors++; end
    endtask

    task automatic test_load_use();
        apply_reset();
        next_cycle();
        loadE = 1'b1; rdE_wrt = 1'b1; rdE = 5'd5; rs1D = 5'd5; rs1_used = 1'b1;
        #1;
        checks++; if (ctl !== 5'b11001) begin $display("FAIL load_use_rs1: got %b exp %b", ctl, 5'b11001); errors++; end
        next_cycle();
        #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL load_use_release: got %b exp %b", ctl, 5'b00000); errors++; end
        checks++; if (scnt !== 32'd1) begin $display("FAIL load_use_cnt: got %0d exp 1", scnt); errors++; end
        next_cycle();
        loadE = 1'b1; rdE_wrt = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs1_used = 1'b1;
        #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL load_use_x0: got %b exp %b", ctl, 5'b00000); errors++; end
        next_cycle();
        loadE = 1'b1; rdE_wrt = 1'b1; rdE = 5'd9; rs2D = 5'd9; rs2_used = 1'b1;
        #1;
        checks++; if (ctl !== 5'b11001) begin $display("FAIL load_use_rs2: got %b exp %b", ctl, 5'b11001); errors++; end
        next_cycle();
        loadE = 1'b1; rdE_wrt = 1'b1; rdE = 5'd9; rs1D = 5'd9; rs1_used = 1'b0;
        #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL load_use_unused: got %b exp %b", ctl, 5'b00000); errors++; end
        next_cycle();
        loadE = 1'b0; rdE_wrt = 1'b1; rdE = 5'd5; rs1D = 5'd5; rs1_used = 1'b1;
        #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL alu_no_stall: got %b exp %b", ctl, 5'b00000); errors++; end
    endtask

    task automatic test_redirect();
        apply_reset();
        next_cycle(); next_pc = 1'b1; #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL redirect_c1: got %b exp %b", ctl, 5'b00011); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL redirect_c2: got %b exp %b", ctl, 5'b00011); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL redirect_done: got %b exp %b", ctl, 5'b00000); errors++; end
        next_cycle(); next_pc = 1'b1; #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL restart_c1: got %b exp %b", ctl, 5'b00011); errors++; end
        next_cycle(); next_pc = 1'b1; #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL restart_c2: got %b exp %b", ctl, 5'b00011); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL restart_c3: got %b exp %b", ctl, 5'b00011); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL restart_done: got %b exp %b", ctl, 5'b00000); errors++; end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            next_cycle(); req = 1'b1; #1;
            checks++; if (ctl !== 5'b11100) begin $display("FAIL mem_wait_c%0d: got %b exp %b", i, ctl, 5'b11100); errors++; end
        end
        next_cycle(); req = 1'b1; ack = 1'b1; #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL mem_ack: got %b exp %b", ctl, 5'b00000); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL mem_after: got %b exp %b", ctl, 5'b00000); errors++; end
        checks++; if (scnt !== 32'd3) begin $display("FAIL mem_cnt: got %0d exp 3", scnt); errors++; end
        next_cycle(); req = 1'b1; ack = 1'b1; #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL zero_wait: got %b exp %b", ctl, 5'b00000); errors++; end
        next_cycle(); #1;
        checks++; if (scnt !== 32'd3) begin $display("FAIL zero_wait_cnt: got %0d exp 3", scnt); errors++; end
    endtask

    task automatic test_redirect_in_wait();
        apply_reset();
        next_cycle(); req = 1'b1; #1;
        checks++; if (ctl !== 5'b11100) begin $display("FAIL rw_c1: got %b exp %b", ctl, 5'b11100); errors++; end
        next_cycle(); req = 1'b1; next_pc = 1'b1; #1;
        checks++; if (ctl !== 5'b11100) begin $display("FAIL rw_redirect: got %b exp %b", ctl, 5'b11100); errors++; end
        next_cycle(); req = 1'b1; #1;
        checks++; if (ctl !== 5'b11100) begin $display("FAIL rw_c3: got %b exp %b", ctl, 5'b11100); errors++; end
        next_cycle(); req = 1'b1; ack = 1'b1; #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL rw_ack: got %b exp %b", ctl, 5'b00000); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL rw_flush1: got %b exp %b", ctl, 5'b00011); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL rw_flush2: got %b exp %b", ctl, 5'b00011); errors++; end
        next_cycle(); #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL rw_done: got %b exp %b", ctl, 5'b00000); errors++; end
    endtask

    task automatic test_forwarding();
        apply_reset();
        next_cycle();
        rdM = 5'd7; rdM_valid = 1'b1; rdW = 5'd7; rdW_valid = 1'b1; rs1D = 5'd7; rs2D = 5'd7;
        #1;
        checks++; if (fwd1 !== 2'b01) begin $display("FAIL fwd_m_beats_w: got %b exp %b", fwd1, 2'b01); errors++; end
        next_cycle();
        rdM = 5'd7; rdM_valid = 1'b0; rdW = 5'd7; rdW_valid = 1'b1; rs1D = 5'd7;
        #1;
        checks++; if (fwd1 !== 2'b10) begin $display("FAIL fwd_w_only: got %b exp %b", fwd1, 2'b10); errors++; end
        next_cycle();
        rdM = 5'd0; rdM_valid = 1'b1; rdW = 5'd0; rdW_valid = 1'b1; rs1D = 5'd0; rs2D = 5'd0;
        #1;
        checks++; if (fwd1 !== 2'b00) begin $display("FAIL fwd_x0_rs1: got %b exp %b", fwd1, 2'b00); errors++; end
        checks++; if (fwd2 !== 2'b00) begin $display("FAIL fwd_x0_rs2: got %b exp %b", fwd2, 2'b00); errors++; end
        next_cycle();
        rdM = 5'd3; rdM_valid = 1'b1; rdW = 5'd4; rdW_valid = 1'b1; rs1D = 5'd4; rs2D = 5'd3;
        #1;
        checks++; if (fwd1 !== 2'b10) begin $display("FAIL fwd_split_rs1: got %b exp %b", fwd1, 2'b10); errors++; end
        checks++; if (fwd2 !== 2'b01) begin $display("FAIL fwd_split_rs2: got %b exp %b", fwd2, 2'b01); errors++; end
    endtask

    task automatic test_reset_in_flush();
        apply_reset();
        next_cycle(); req = 1'b1; #1;
        next_cycle(); req = 1'b1; ack = 1'b1; next_pc = 1'b1; #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL rf_ack: got %b exp %b", ctl, 5'b00000); errors++; end
        next_cycle(); rst = 1'b1; rdM = 5'd2; rdM_valid = 1'b1; rs2D = 5'd2; #1;
        checks++; if (ctl !== 5'b00011) begin $display("FAIL rf_in_reset: got %b exp %b", ctl, 5'b00011); errors++; end
        checks++; if (fwd2 !== 2'b00) begin $display("FAIL rf_fwd_reset: got %b exp %b", fwd2, 2'b00); errors++; end
        next_cycle(); rst = 1'b0; #1;
        checks++; if (ctl !== 5'b00000) begin $display("FAIL rf_aborted: got %b exp %b", ctl, 5'b00000); errors++; end
        checks++; if (scnt !== 32'd0) begin $display("FAIL rf_cnt: got %0d exp 0", scnt); errors++; end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            next_cycle(); req = 1'b1;
        end
        next_cycle(); req = 1'b1; ack = 1'b1; #1;
        checks++; if (s_scnt !== 2'b11) begin $display("FAIL sat_cnt: got %0d exp 3", s_scnt); errors++; end
        checks++; if (scnt !== 32'd5) begin $display("FAIL wide_cnt: got %0d exp 5", scnt); errors++; end
        next_cycle(); next_pc = 1'b1; #1;
        checks++; if (s_ctl !== 5'b00011) begin $display("FAIL fc1_flush: got %b exp %b", s_ctl, 5'b00011); errors++; end
        next_cycle(); #1;
        checks++; if (s_ctl !== 5'b00000) begin $display("FAIL fc1_done: got %b exp %b", s_ctl, 5'b00000); errors++; end
        checks++; if (ctl !== 5'b00011) begin $display("FAIL fc2_still: got %b exp %b", ctl, 5'b00011); errors++; end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_redirect_in_wait();
        test_forwarding();
        test_reset_in_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
